bist_ctrl: RTL and testbench

Self-test controller for the 10-bit signature path. It generates pseudo-random test patterns with an internal Galois LFSR and drives the MISR's reset and enable. After a programmable flush it compares the MISR signature against a golden value and reports pass/fail. It sits directly upstream of the MISR: its `misr_reset` and `misr_enable` feed the MISR's `reset` and `enable`, and the MISR's `out_misr` returns on `misr_sig`.

---
 rtl/bist_ctrl.sv | 155 +++++++++++++++
 tb/tb_bist_ctrl.sv | 341 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bist_ctrl.sv
// bist_ctrl: BIST sequencer for the 10-bit signature path.
// Drives LFSR patterns into the CUT and controls the downstream MISR.
// After the patterns and a flush, it compares the signature against a golden value.
module bist_ctrl #(
  parameter int unsigned       WIDTH        = 10,
  parameter int unsigned       N_PATTERNS   = 1023,
  parameter logic [WIDTH-1:0]  LFSR_SEED    = 10'h001,
  parameter logic [WIDTH-1:0]  LFSR_TAPS    = 10'h009,
  parameter int unsigned       FLUSH_CYCLES = 2,
  parameter int unsigned       CW           = $clog2(N_PATTERNS + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] golden_sig,
  input  logic [WIDTH-1:0] misr_sig,
  output logic [WIDTH-1:0] pattern,
  output logic             bist_mode,
  output logic             misr_reset,
  output logic             misr_enable,
  output logic [CW-1:0]    pattern_count,
  output logic             busy,
  output logic             done,
  output logic             pass
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_CLEAR = 3'd1;
  localparam logic [2:0] S_RUN   = 3'd2;
  localparam logic [2:0] S_FLUSH = 3'd3;
  localparam logic [2:0] S_CHECK = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;

  localparam int unsigned  FCW        = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam logic [CW-1:0]  LAST_PAT   = CW'(N_PATTERNS - 1);
  localparam logic [FCW-1:0] LAST_FLUSH = FCW'(FLUSH_CYCLES - 1);

  // Parameter sanity: a zero seed locks the LFSR, and a run needs at least one pattern.
  if (LFSR_SEED == '0) begin : g_bad_seed
    $error("bist_ctrl: LFSR_SEED must be nonzero");
  end
  if (N_PATTERNS < 1) begin : g_bad_count
    $error("bist_ctrl: N_PATTERNS must be at least 1");
  end

  logic [2:0]       state_q, state_d;
  logic             start_q;
  logic [WIDTH-1:0] lfsr_q, lfsr_d;
  logic [FCW-1:0]   flush_cnt_q, flush_cnt_d;
  logic [WIDTH-1:0] pattern_q, pattern_d;
  logic             bist_mode_q, bist_mode_d;
  logic             misr_reset_q, misr_reset_d;
  logic             misr_enable_q, misr_enable_d;
  logic [CW-1:0]    pattern_count_q, pattern_count_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             pass_q, pass_d;
  logic             start_evt_c;
  logic [WIDTH-1:0] lfsr_step_c;

  // Rising edge of start, and the Galois step of the current LFSR state.
  assign start_evt_c = start & ~start_q;
  assign lfsr_step_c = {lfsr_q[WIDTH-2:0], 1'b0} ^ (lfsr_q[WIDTH-1] ? LFSR_TAPS : '0);

  // Next-state logic for the run sequence.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start_evt_c) state_d = S_CLEAR;
      S_CLEAR: state_d = S_RUN;
      S_RUN:   if (pattern_count_q == LAST_PAT) state_d = (FLUSH_CYCLES == 0) ? S_CHECK : S_FLUSH;
      S_FLUSH: if (flush_cnt_q == LAST_FLUSH) state_d = S_CHECK;
      S_CHECK: state_d = S_DONE;
      S_DONE:  if (start_evt_c) state_d = S_CLEAR;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath and output next values. Controls are decoded from the next state so they are valid while that state is current.
  always_comb begin
    lfsr_d          = lfsr_q;
    flush_cnt_d     = flush_cnt_q;
    pattern_d       = pattern_q;
    pattern_count_d = pattern_count_q;
    pass_d          = pass_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start_evt_c) begin
          lfsr_d          = LFSR_SEED;
          pattern_count_d = '0;
          pass_d          = 1'b0;
        end
      end
      S_CLEAR: begin
        pattern_d   = lfsr_q;
        flush_cnt_d = '0;
      end
      S_RUN: begin
        lfsr_d          = lfsr_step_c;
        pattern_count_d = pattern_count_q + CW'(1);
        if (state_d == S_RUN) pattern_d = lfsr_step_c;
      end
      S_FLUSH: flush_cnt_d = flush_cnt_q + FCW'(1);
      S_CHECK: pass_d = (misr_sig == golden_sig);
      default: ;
    endcase
    misr_reset_d  = (state_d == S_CLEAR);
    misr_enable_d = (state_d == S_RUN) || (state_d == S_FLUSH);
    busy_d        = (state_d == S_CLEAR) || (state_d == S_RUN) ||
                    (state_d == S_FLUSH) || (state_d == S_CHECK);
    bist_mode_d   = busy_d;
    done_d        = (state_d == S_DONE);
  end

  // State and output registers; reset parks everything in IDLE with outputs low.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q         <= S_IDLE;
      start_q         <= 1'b0;
      lfsr_q          <= LFSR_SEED;
      flush_cnt_q     <= '0;
      pattern_q       <= '0;
      bist_mode_q     <= 1'b0;
      misr_reset_q    <= 1'b0;
      misr_enable_q   <= 1'b0;
      pattern_count_q <= '0;
      busy_q          <= 1'b0;
      done_q          <= 1'b0;
      pass_q          <= 1'b0;
    end else begin
      state_q         <= state_d;
      start_q         <= start;
      lfsr_q          <= lfsr_d;
      flush_cnt_q     <= flush_cnt_d;
      pattern_q       <= pattern_d;
      bist_mode_q     <= bist_mode_d;
      misr_reset_q    <= misr_reset_d;
      misr_enable_q   <= misr_enable_d;
      pattern_count_q <= pattern_count_d;
      busy_q          <= busy_d;
      done_q          <= done_d;
      pass_q          <= pass_d;
    end
  end

  assign pattern       = pattern_q;
  assign bist_mode     = bist_mode_q;
  assign misr_reset    = misr_reset_q;
  assign misr_enable   = misr_enable_q;
  assign pattern_count = pattern_count_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign pass          = pass_q;

endmodule

// File: tb/tb_bist_ctrl.sv
// Testbench for bist_ctrl: a default-parameter instance and a 12-pattern instance, each feeding a bench MISR.
module tb_bist_ctrl;

  localparam int RUN_BUDGET = 1200;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic       start12 = 1'b0;
  logic [9:0] golden_sig = '0;
  logic [9:0] golden12 = '0;
  logic [9:0] misr_q = '0;
  logic [9:0] misr12_q = '0;

  logic [9:0] pattern, pattern12;
  logic       bist_mode, misr_reset, misr_enable, busy, done, pass;
  logic       bist_mode12, misr_reset12, misr_enable12, busy12, done12, pass12;
  logic [9:0] pattern_count;
  logic [3:0] pattern_count12;

  int n_checks = 0;
  int n_errors = 0;

  logic [9:0] exp_pat_q[$];
  logic [9:0] obs_pat_q[$];
  int         en_cnt, busy_cnt, rst_cnt;
  bit         overlap;
  logic       snap_done, snap_pass, snap_reset, snap_busy;
  logic [9:0] snap_count;

  always #5 clk = ~clk;

  bist_ctrl dut (
    .clk(clk), .reset(reset), .start(start), .golden_sig(golden_sig), .misr_sig(misr_q),
    .pattern(pattern), .bist_mode(bist_mode), .misr_reset(misr_reset), .misr_enable(misr_enable),
    .pattern_count(pattern_count), .busy(busy), .done(done), .pass(pass)
  );

  bist_ctrl #(.N_PATTERNS(12)) dut12 (
    .clk(clk), .reset(reset), .start(start12), .golden_sig(golden12), .misr_sig(misr12_q),
    .pattern(pattern12), .bist_mode(bist_mode12), .misr_reset(misr_reset12), .misr_enable(misr_enable12),
    .pattern_count(pattern_count12), .busy(busy12), .done(done12), .pass(pass12)
  );

  function automatic logic [9:0] lfsr_next(input logic [9:0] s);
    return {s[8:0], 1'b0} ^ (s[9] ? 10'h009 : 10'h000);
  endfunction

  function automatic logic [9:0] misr_next(input logic [9:0] m, input logic [9:0] d);
    return ({m[8:0], 1'b0} ^ (m[9] ? 10'h081 : 10'h000)) ^ d;
  endfunction

  // Bench MISRs with synchronous clear, as the real MISR behaves.
  always @(posedge clk) begin
    if (misr_reset) misr_q <= '0;
    else if (misr_enable) misr_q <= misr_next(misr_q, pattern);
    if (misr_reset12) misr12_q <= '0;
    else if (misr_enable12) misr12_q <= misr_next(misr12_q, pattern12);
  end

  // Reference model: fills the expected pattern queue and returns the signature.
  task automatic build_expected(input int n, input int f, output logic [9:0] sig);
    logic [9:0] p, last, m;
    exp_pat_q.delete();
    p = 10'h001; last = p; m = '0;
    for (int k = 0; k < n; k++) begin
      exp_pat_q.push_back(p);
      m = misr_next(m, p);
      last = p;
      p = lfsr_next(p);
    end
    for (int k = 0; k < f; k++) begin
      exp_pat_q.push_back(last);
      m = misr_next(m, last);
    end
    sig = m;
  endtask

  function automatic int seq_mismatches();
    int mm = 0;
    if (obs_pat_q.size() != exp_pat_q.size()) mm++;
    while (exp_pat_q.size() > 0 && obs_pat_q.size() > 0) begin
      if (exp_pat_q.pop_front() !== obs_pat_q.pop_front()) mm++;
    end
    exp_pat_q.delete();
    obs_pat_q.delete();
    return mm;
  endfunction

  // Launch a run on the default instance and record activity until done or budget expiry.
  task automatic run_dut(input bit hold, input int pulse_at, output int cycles);
    int n = 0;
    en_cnt = 0; busy_cnt = 0; rst_cnt = 0; overlap = 1'b0;
    obs_pat_q.delete();
    start = 1'b1;
    do begin
      @(negedge clk);
      n++;
      if (n == 1) begin
        snap_done = done; snap_pass = pass; snap_reset = misr_reset;
        snap_busy = busy; snap_count = pattern_count;
      end
      if (!hold) start = (n == pulse_at);
      if (misr_enable === 1'b1) begin en_cnt++; obs_pat_q.push_back(pattern); end
      if (busy === 1'b1) busy_cnt++;
      if (misr_reset === 1'b1) rst_cnt++;
      if (busy === 1'b1 && done === 1'b1) overlap = 1'b1;
    end while (done !== 1'b1 && n < RUN_BUDGET);
    cycles = (done === 1'b1) ? n - 1 : -1;
  endtask

  task automatic test_reset();
    logic [25:0] outs;
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      start = ~start; start12 = ~start12;
      outs = {pattern, bist_mode, misr_reset, misr_enable, pattern_count, busy, done, pass};
      n_checks++;
      if (outs !== 26'd0) begin
        n_errors++; $display("FAIL reset_outputs cyc%0d: got %h expected 0", i, outs);
      end
      n_checks++;
      if ({misr_reset12, misr_enable12, busy12, done12, bist_mode12} !== 5'd0) begin
        n_errors++; $display("FAIL reset_outputs12 cyc%0d: got %b expected 0", i,
                             {misr_reset12, misr_enable12, busy12, done12, bist_mode12});
      end
    end
    @(negedge clk);
    start = 1'b0; start12 = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_checks++;
      if ({busy, bist_mode, misr_enable, misr_reset, done} !== 5'd0) begin
        n_errors++; $display("FAIL idle_after_reset cyc%0d: got %b expected 0", i,
                             {busy, bist_mode, misr_enable, misr_reset, done});
      end
    end
  endtask

  task automatic test_lfsr_seq();
    logic [9:0] seq [12];
    logic [9:0] e;
    int n = 0;
    int en = 0;
    build_expected(12, 2, golden12);
    seq = '{10'h001, 10'h002, 10'h004, 10'h008, 10'h010, 10'h020,
            10'h040, 10'h080, 10'h100, 10'h200, 10'h009, 10'h012};
    exp_pat_q.delete();
    for (int i = 0; i < 12; i++) exp_pat_q.push_back(seq[i]);
    exp_pat_q.push_back(seq[11]);
    exp_pat_q.push_back(seq[11]);
    start12 = 1'b1;
    do begin
      @(negedge clk);
      n++;
      start12 = 1'b0;
      if (misr_enable12 === 1'b1) begin
        en++;
        e = (exp_pat_q.size() > 0) ? exp_pat_q.pop_front() : 10'h3ff;
        n_checks++;
        if (pattern12 !== e) begin
          n_errors++; $display("FAIL lfsr_pattern #%0d: got %h expected %h", en, pattern12, e);
        end
      end
    end while (done12 !== 1'b1 && n < 60);
    n_checks++;
    if (en != 14) begin n_errors++; $display("FAIL lfsr_enable_cycles: got %0d expected 14", en); end
    n_checks++;
    if (pattern_count12 !== 4'd12) begin
      n_errors++; $display("FAIL lfsr_pattern_count: got %0d expected 12", pattern_count12);
    end
    n_checks++;
    if (n - 1 != 16) begin n_errors++; $display("FAIL lfsr_done_latency: got %0d expected 16", n - 1); end
    n_checks++;
    if (pass12 !== 1'b1) begin n_errors++; $display("FAIL lfsr_pass: got %b expected 1", pass12); end
    exp_pat_q.delete();
  endtask

  task automatic test_pass_run();
    int c;
    int mm;
    build_expected(1023, 2, golden_sig);
    run_dut(1'b0, -1, c);
    mm = seq_mismatches();
    n_checks++;
    if (c != 1027) begin n_errors++; $display("FAIL pass_run_latency: got %0d expected 1027", c); end
    n_checks++;
    if (pass !== 1'b1) begin n_errors++; $display("FAIL pass_run_pass: got %b expected 1", pass); end
    n_checks++;
    if (pattern_count !== 10'd1023) begin
      n_errors++; $display("FAIL pass_run_count: got %0d expected 1023", pattern_count);
    end
    n_checks++;
    if (mm != 0) begin n_errors++; $display("FAIL pass_run_patterns: got %0d mismatches expected 0", mm); end
    n_checks++;
    if (en_cnt != 1025) begin n_errors++; $display("FAIL pass_run_enable: got %0d expected 1025", en_cnt); end
    n_checks++;
    if (busy_cnt != 1027) begin n_errors++; $display("FAIL pass_run_busy: got %0d expected 1027", busy_cnt); end
    n_checks++;
    if (rst_cnt != 1) begin n_errors++; $display("FAIL pass_run_misr_reset: got %0d expected 1", rst_cnt); end
    n_checks++;
    if (overlap) begin n_errors++; $display("FAIL pass_run_busy_done_overlap: got 1 expected 0"); end
    n_checks++;
    if ({busy, bist_mode} !== 2'b00) begin
      n_errors++; $display("FAIL pass_run_done_outputs: got %b expected 00", {busy, bist_mode});
    end
  endtask

  task automatic test_fail_run();
    int c;
    int mm;
    logic [9:0] g;
    build_expected(1023, 2, g);
    golden_sig = g ^ 10'h010;
    @(negedge clk);
    run_dut(1'b0, -1, c);
    mm = seq_mismatches();
    n_checks++;
    if (c != 1027) begin n_errors++; $display("FAIL fail_run_latency: got %0d expected 1027", c); end
    n_checks++;
    if (pass !== 1'b0) begin n_errors++; $display("FAIL fail_run_pass: got %b expected 0", pass); end
    n_checks++;
    if (mm != 0) begin n_errors++; $display("FAIL fail_run_patterns: got %0d mismatches expected 0", mm); end
  endtask

  task automatic test_start_ignored();
    int c;
    int mm;
    build_expected(1023, 2, golden_sig);
    @(negedge clk);
    run_dut(1'b0, 300, c);
    mm = seq_mismatches();
    n_checks++;
    if (c != 1027) begin n_errors++; $display("FAIL start_in_run_latency: got %0d expected 1027", c); end
    n_checks++;
    if (pass !== 1'b1) begin n_errors++; $display("FAIL start_in_run_pass: got %b expected 1", pass); end
    n_checks++;
    if (rst_cnt != 1) begin n_errors++; $display("FAIL start_in_run_clears: got %0d expected 1", rst_cnt); end
    n_checks++;
    if (mm != 0) begin n_errors++; $display("FAIL start_in_run_patterns: got %0d mismatches expected 0", mm); end
  endtask

  task automatic test_start_held();
    int c;
    int bad = 0;
    build_expected(1023, 2, golden_sig);
    @(negedge clk);
    run_dut(1'b1, -1, c);
    void'(seq_mismatches());
    n_checks++;
    if (c != 1027) begin n_errors++; $display("FAIL held_latency: got %0d expected 1027", c); end
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done !== 1'b1 || busy !== 1'b0 || misr_reset !== 1'b0) bad++;
    end
    n_checks++;
    if (bad != 0) begin n_errors++; $display("FAIL held_no_retrigger: got %0d bad cycles expected 0", bad); end
  endtask

  task automatic test_restart();
    int c;
    int mm;
    start = 1'b0;
    @(negedge clk);
    build_expected(1023, 2, golden_sig);
    run_dut(1'b0, -1, c);
    mm = seq_mismatches();
    n_checks++;
    if ({snap_done, snap_pass} !== 2'b00) begin
      n_errors++; $display("FAIL restart_clear_done_pass: got %b expected 00", {snap_done, snap_pass});
    end
    n_checks++;
    if ({snap_reset, snap_busy} !== 2'b11) begin
      n_errors++; $display("FAIL restart_clear_reset_busy: got %b expected 11", {snap_reset, snap_busy});
    end
    n_checks++;
    if (snap_count !== 10'd0) begin n_errors++; $display("FAIL restart_clear_count: got %0d expected 0", snap_count); end
    n_checks++;
    if (c != 1027) begin n_errors++; $display("FAIL restart_latency: got %0d expected 1027", c); end
    n_checks++;
    if (pass !== 1'b1) begin n_errors++; $display("FAIL restart_pass: got %b expected 1", pass); end
    n_checks++;
    if (mm != 0) begin n_errors++; $display("FAIL restart_patterns: got %0d mismatches expected 0", mm); end
  endtask

  task automatic test_reset_mid_run();
    int n = 0;
    int c;
    int mm;
    logic [25:0] outs;
    start = 1'b1;
    do begin
      @(negedge clk);
      n++;
      start = 1'b0;
    end while (pattern_count !== 10'd500 && n < 600);
    n_checks++;
    if ({pattern_count, misr_enable, busy} !== {10'd500, 2'b11}) begin
      n_errors++; $display("FAIL midrun_reach_500: got %0d/%b%b expected 500/11",
                           pattern_count, misr_enable, busy);
    end
    reset = 1'b0;
    #1;
    outs = {pattern, bist_mode, misr_reset, misr_enable, pattern_count, busy, done, pass};
    n_checks++;
    if (outs !== 26'd0) begin n_errors++; $display("FAIL midrun_async_reset: got %h expected 0", outs); end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    build_expected(1023, 2, golden_sig);
    run_dut(1'b0, -1, c);
    mm = seq_mismatches();
    n_checks++;
    if (c != 1027) begin n_errors++; $display("FAIL midrun_rerun_latency: got %0d expected 1027", c); end
    n_checks++;
    if (pass !== 1'b1) begin n_errors++; $display("FAIL midrun_rerun_pass: got %b expected 1", pass); end
    n_checks++;
    if (pattern_count !== 10'd1023) begin
      n_errors++; $display("FAIL midrun_rerun_count: got %0d expected 1023", pattern_count);
    end
    n_checks++;
    if (mm != 0) begin n_errors++; $display("FAIL midrun_rerun_patterns: got %0d mismatches expected 0", mm); end
  endtask

  initial begin
    test_reset();
    test_lfsr_seq();
    test_pass_run();
    test_fail_run();
    test_start_ignored();
    test_start_held();
    test_restart();
    test_reset_mid_run();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
